// File: rtl/egg_timer_sequencer.sv
// Egg timer countdown controller: holds the mm:ss setting, counts it
// down on 1 Hz ticks taken from the divider output, raises a timed alarm.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   startStop  pulse: start / pause / resume / acknowledge alarm
//   clear      pulse: back to 00:00 IDLE from any state
//   incMinute  pulse: minutes +1 (wraps above MAX_MINUTES)
//   incSecond  pulse: seconds +1 (wraps above 59, no carry)
//   divClk     divider square-wave output, same clock domain
//   divEnable  divider write enable, high in RUN and ALARM
//   minutes    current minutes value
//   seconds    current seconds value
//   state      IDLE=0 SET=1 RUN=2 PAUSE=3 ALARM=4
//   alarm      high while in ALARM

module egg_timer_sequencer #(
    parameter int MAX_MINUTES   = 99,
    parameter int ALARM_SECONDS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startStop,
    input  logic       clear,
    input  logic       incMinute,
    input  logic       incSecond,
    input  logic       divClk,
    output logic       divEnable,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] state,
    output logic       alarm
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam logic [6:0] MAX_MIN   = 7'(MAX_MINUTES);
    localparam logic [7:0] ALARM_CNT = 8'(ALARM_SECONDS);

    state_t     state_q, state_d;
    logic [6:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       prev_q;
    logic       diven_q;
    logic       alarm_q;

    logic       tick;
    logic [6:0] min_inc;
    logic [5:0] sec_inc;
    logic [7:0] cnt_inc;
    logic [6:0] ed_min;
    logic [5:0] ed_sec;
    logic [6:0] dec_min;
    logic [5:0] dec_sec;

    assign tick    = divClk & ~prev_q;
    assign min_inc = (min_q == MAX_MIN) ? 7'd0 : min_q + 7'd1;
    assign sec_inc = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    assign cnt_inc = cnt_q + 8'd1;

    // One-second decrement with borrow from minutes.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != 6'd0) begin
            dec_sec = sec_q - 6'd1;
        end else if (min_q != 7'd0) begin
            dec_min = min_q - 7'd1;
            dec_sec = 6'd59;
        end
    end

    // Only one increment is applied; incMinute outranks incSecond.
    always_comb begin
        ed_min = min_q;
        ed_sec = sec_q;
        if (incMinute) begin
            ed_min = min_inc;
        end else begin
            ed_sec = sec_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            min_d   = 7'd0;
            sec_d   = 6'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_SET, ST_PAUSE: begin
                    // startStop in IDLE is swallowed, and so are
                    // any lower-priority increments alongside it.
                    if (startStop) begin
                        if (state_q != ST_IDLE) begin
                            state_d = ST_RUN;
                        end
                    end else if (incMinute || incSecond) begin
                        min_d = ed_min;
                        sec_d = ed_sec;
                        if (ed_min == 7'd0 && ed_sec == 6'd0) begin
                            state_d = ST_IDLE;
                        end else if (state_q == ST_IDLE) begin
                            state_d = ST_SET;
                        end
                    end
                end
                ST_RUN: begin
                    if (startStop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        min_d = dec_min;
                        sec_d = dec_sec;
                        if (dec_min == 7'd0 && dec_sec == 6'd0) begin
                            state_d = ST_ALARM;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                ST_ALARM: begin
                    if (startStop) begin
                        state_d = ST_IDLE;
                        min_d   = 7'd0;
                        sec_d   = 6'd0;
                        cnt_d   = 8'd0;
                    end else if (tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == ALARM_CNT) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    min_d   = 7'd0;
                    sec_d   = 6'd0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up
    // with the state register without a decode after the flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= 7'd0;
            sec_q   <= 6'd0;
            cnt_q   <= 8'd0;
            prev_q  <= 1'b0;
            diven_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
            prev_q  <= divClk;
            diven_q <= (state_d == ST_RUN) || (state_d == ST_ALARM);
            alarm_q <= (state_d == ST_ALARM);
        end
    end

    assign divEnable = diven_q;
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign state     = state_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_egg_timer_sequencer.sv
// Bench for egg_timer_sequencer: a time-in-seconds reference model
// checked every cycle, plus hand-computed literal checkpoints.

module tb_egg_timer_sequencer;

    localparam int MAXM = 99;
    localparam int ALS  = 30;

    localparam int S_IDLE  = 0;
    localparam int S_SET   = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_ALARM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startStop = 1'b0;
    logic       clear = 1'b0;
    logic       incMinute = 1'b0;
    logic       incSecond = 1'b0;
    logic       divClk = 1'b0;
    logic       divEnable;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [2:0] state;
    logic       alarm;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    egg_timer_sequencer #(
        .MAX_MINUTES(MAXM),
        .ALARM_SECONDS(ALS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startStop(startStop),
        .clear(clear),
        .incMinute(incMinute),
        .incSecond(incSecond),
        .divClk(divClk),
        .divEnable(divEnable),
        .minutes(minutes),
        .seconds(seconds),
        .state(state),
        .alarm(alarm)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: remaining time kept as total seconds,
    // alarm as ticks left to ring.
    int m_t;
    int m_st;
    int m_left;
    bit m_prev;
    bit m_tick;
    int m_mm;
    int m_ss;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t    = 0;
            m_st   = S_IDLE;
            m_left = 0;
            m_prev = 1'b0;
        end else begin
            m_tick = divClk && !m_prev;
            m_prev = divClk;
            if (clear) begin
                m_st = S_IDLE;
                m_t  = 0;
            end else if (startStop) begin
                if (m_st == S_SET || m_st == S_PAUSE) begin
                    m_st = S_RUN;
                end else if (m_st == S_RUN) begin
                    m_st = S_PAUSE;
                end else if (m_st == S_ALARM) begin
                    m_st = S_IDLE;
                    m_t  = 0;
                end
            end else if ((incMinute || incSecond) &&
                         (m_st == S_IDLE || m_st == S_SET ||
                          m_st == S_PAUSE)) begin
                m_mm = m_t / 60;
                m_ss = m_t % 60;
                if (incMinute) m_mm = (m_mm == MAXM) ? 0 : m_mm + 1;
                else m_ss = (m_ss + 1) % 60;
                m_t = m_mm * 60 + m_ss;
                if (m_t == 0) m_st = S_IDLE;
                else if (m_st == S_IDLE) m_st = S_SET;
            end else if (m_tick && m_st == S_RUN) begin
                m_t = m_t - 1;
                if (m_t == 0) begin
                    m_st   = S_ALARM;
                    m_left = ALS;
                end
            end else if (m_tick && m_st == S_ALARM) begin
                m_left = m_left - 1;
                if (m_left == 0) m_st = S_IDLE;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_min", int'(minutes), m_t / 60);
        chk("model_sec", int'(seconds), m_t % 60);
        chk("model_state", int'(state), m_st);
        chk("model_divEnable", int'(divEnable),
            int'(m_st == S_RUN || m_st == S_ALARM));
        chk("model_alarm", int'(alarm), int'(m_st == S_ALARM));
    end

    task automatic cyc(input logic ss, input logic cl, input logic im,
                       input logic is, input logic dc);
        @(posedge clk);
        #2;
        startStop = ss;
        clear     = cl;
        incMinute = im;
        incSecond = is;
        divClk    = dc;
    endtask

    task automatic press(input logic ss, input logic cl,
                         input logic im, input logic is);
        cyc(ss, cl, im, is, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all(input string nm, input int st, input int mm,
                           input int ss, input int de, input int al);
        chk({nm, "_state"}, int'(state), st);
        chk({nm, "_min"}, int'(minutes), mm);
        chk({nm, "_sec"}, int'(seconds), ss);
        chk({nm, "_divEnable"}, int'(divEnable), de);
        chk({nm, "_alarm"}, int'(alarm), al);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0);

        press(0, 0, 1, 0);
        repeat (3) press(0, 0, 0, 1);
        chk_all("set_0103", 1, 1, 3, 0, 0);
        press(1, 0, 0, 0);
        chk_all("run_0103", 2, 1, 3, 1, 0);

        repeat (3) tick();
        chk_all("run_0100", 2, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_all("edge_0059", 2, 0, 59, 1, 0);
        repeat (5) cyc(0, 0, 0, 0, 1);
        chk_all("held_high", 2, 0, 59, 1, 0);
        cyc(0, 0, 0, 0, 0);

        repeat (58) tick();
        chk_all("run_0001", 2, 0, 1, 1, 0);
        tick();
        chk_all("alarm_enter", 4, 0, 0, 1, 1);
        repeat (29) tick();
        chk_all("alarm_29", 4, 0, 0, 1, 1);
        tick();
        chk_all("alarm_done", 0, 0, 0, 0, 0);

        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        tick();
        chk_all("alarm2_enter", 4, 0, 0, 1, 1);
        repeat (5) tick();
        press(1, 0, 0, 0);
        chk_all("alarm_ack", 0, 0, 0, 0, 0);

        repeat (2) press(0, 0, 1, 0);
        repeat (30) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk_all("run_0230", 2, 2, 30, 1, 0);
        press(1, 0, 0, 0);
        chk_all("pause_0230", 3, 2, 30, 0, 0);
        repeat (10) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
        chk_all("pause_toggle", 3, 2, 30, 0, 0);
        press(1, 0, 0, 0);
        chk_all("resume", 2, 2, 30, 1, 0);
        tick();
        chk_all("resume_tick", 2, 2, 29, 1, 0);

        press(0, 1, 0, 0);
        chk_all("clear", 0, 0, 0, 0, 0);
        repeat (59) press(0, 0, 0, 1);
        chk_all("set_0059", 1, 0, 59, 0, 0);
        press(0, 0, 0, 1);
        chk_all("sec_wrap", 0, 0, 0, 0, 0);
        repeat (99) press(0, 0, 1, 0);
        chk_all("set_9900", 1, 99, 0, 0, 0);
        press(0, 0, 1, 0);
        chk_all("min_wrap", 0, 0, 0, 0, 0);
        press(1, 0, 0, 0);
        chk_all("ss_idle", 0, 0, 0, 0, 0);

        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk_all("run_0001b", 2, 0, 1, 1, 0);
        press(1, 1, 0, 0);
        chk_all("clear_ss", 0, 0, 0, 0, 0);

        repeat (5) press(0, 0, 1, 0);
        repeat (17) press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        chk_all("run_0517", 2, 5, 17, 1, 0);
        #1;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk_all("post_reset", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
